nibble_serial_adder: RTL

//   Multi-cycle WIDTH-bit adder sequencer for the datapath. It slices two latched

---
 rtl/nibble_serial_adder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that time-shares one external 4-bit slice, LSB nibble first.
// Optional macro SUBTRACT_EN adds a 'sub' input selecting a - b.
`timescale 1ns/1ps

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic [3:0]       nib_a,
  output logic [3:0]       nib_b,
  output logic             nib_cin,
  input  logic [3:0]       nib_sum,
  input  logic             nib_cout
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_cin;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [IDX_W+1:0]   w_bit_base;
  logic [WIDTH-1:0]   w_b_eff;
  logic               w_cin_eff;
  logic               w_ovf_next;

  // Operand B and carry-in as seen by the slice; subtract is a + ~b + 1.
`ifdef SUBTRACT_EN
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub ? 1'b1 : cin;
`else
  assign w_b_eff   = b;
  assign w_cin_eff = cin;
`endif

  assign ready    = (r_state == StIdle) || (r_state == StDone);
  assign busy     = (r_state == StRun);
  assign done     = (r_state == StDone);
  assign result   = r_result;
  assign cout     = r_cout;
  assign ovf      = r_ovf;

  assign w_accept   = start & ready;
  assign w_last     = (r_state == StRun) && (r_idx == LAST_IDX);
  assign w_bit_base = {r_idx, 2'b00};

  assign nib_a   = r_a[w_bit_base +: 4];
  assign nib_b   = r_b[w_bit_base +: 4];
  assign nib_cin = (r_idx == '0) ? r_cin : r_carry;

  // Carry into the MSB is recovered from the top slice's bit-3 sum.
  assign w_ovf_next = nib_cout ^ (nib_sum[3] ^ nib_a[3] ^ nib_b[3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StRun;
      StRun:   if (r_idx == LAST_IDX) w_state_next = StDone;
      StDone:  w_state_next = w_accept ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_cin    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_idx    <= '0;
      r_carry  <= w_cin_eff;
      r_cin    <= w_cin_eff;
      r_a      <= a;
      r_b      <= w_b_eff;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_state == StRun) begin
      r_result[w_bit_base +: 4] <= nib_sum;
      r_carry                   <= nib_cout;
      if (w_last) begin
        r_idx  <= '0;
        r_cout <= nib_cout;
        r_ovf  <= w_ovf_next;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

endmodule
